sonic_vc_tx_arbiter: RTL
========================

Name: sonic_vc_tx_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_CH per-virtual-channel Avalon-ST TX sources into the single 133-bit-wide TX FIFO sink (128 data, 2 empty, 1 error, sop, eop).
- Starts a new packet only while the FIFO level is below a high watermark.
- Drops malformed packets (headless beats).
- Keeps forwarded/dropped packet counters for the control-plane CSRs.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_W, 128, data width per beat.
- EMPTY_W, 2, empty field width.
- LEVEL_W, 14, FIFO level width ({full, usedw}).
- HI_WM, 8000, no new grant while fifo_level >= HI_WM.

Ports:
- clock, in, 1, clock.
- reset_n, in, 1, asynchronous, active-low reset.
- in_valid, in, NUM_CH, per-channel beat valid.
- in_data, in, NUM_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- in_empty, in, NUM_CH*EMPTY_W, per-channel empty.
- in_error, in, NUM_CH, per-channel error.
- in_sop, in, NUM_CH, per-channel startofpacket.
- in_eop, in, NUM_CH, per-channel endofpacket.
- in_ready, out, NUM_CH, per-channel ready (ready latency 0: beat taken when valid & ready).
- chan_enable, in, NUM_CH, CSR mask; 0 excludes the channel from new grants.
- fifo_level, in, LEVEL_W, TX FIFO level.
- out_ready, in, 1, FIFO sink ready (ready latency 1).
- out_valid, out, 1, beat valid to FIFO.
- out_data, out, DATA_W, beat data.
- out_empty, out, EMPTY_W, beat empty.
- out_error, out, 1, beat error.
- out_sop, out, 1, beat startofpacket.
- out_eop, out, 1, beat endofpacket.
- grant_ch, out, 3, currently/last granted channel.
- busy, out, 1, 1 in XFER or DROP.
- proto_err, out, 1, one-cycle pulse on malformed-packet detection.
- pkt_count, out, 32, packets forwarded (wraps).
- drop_count, out, 16, packets dropped (saturates at 0xFFFF).

Behaviour:
- Reset (async, reset_n=0) clears:
  - state=IDLE, all out_*=0, in_ready=0, grant_ch=0, busy=0, proto_err=0, both counters=0.
  - RR pointer last=NUM_CH-1, so channel 0 wins first.
  - Reset mid-packet abandons the packet; no eop is emitted.
- FSM states IDLE, XFER, DROP.
- IDLE:
  - Candidates = in_valid & chan_enable.
  - If any candidate and fifo_level < HI_WM, pick the first candidate searching from (last+1) mod NUM_CH; register grant_ch and set last to it.
  - If the picked channel's head beat has in_sop=1, go to XFER; else go to DROP and pulse proto_err.
  - in_ready=0 in IDLE. Arbitration costs 1 cycle per packet.
- XFER:
  - in_ready[grant_ch] = out_ready; all other in_ready=0.
  - An accepted beat is registered onto out_* with out_valid=1 the next cycle, satisfying ready latency 1. out_valid=0 in every other cycle.
  - Accepted beat with in_eop=1: pkt_count+1, return to IDLE.
  - Accepted beat with in_sop=1 after the first beat: forward it with out_eop=1 and out_error=1, pulse proto_err, pkt_count+1, return to IDLE. The new packet's remainder is then headless and takes the DROP path.
  - in_valid low mid-packet: hold the grant indefinitely (no timeout).
  - chan_enable deassert mid-packet: no effect until eop.
  - Watermark checked only in IDLE; an in-flight packet always completes.
- DROP:
  - in_ready[grant_ch]=1 regardless of out_ready; out_valid=0.
  - Consume beats until an accepted beat has eop=1, then drop_count+1 (saturating) and go to IDLE.
- Single-beat packet (sop & eop): IDLE→XFER→IDLE; one output beat.
- Simultaneous requests: strict RR, no channel granted twice while another enabled channel holds a valid head.
- busy=1 exactly in XFER and DROP.

Test Plan:
- Ch0 and ch2 each present 3-beat packets, level=0, out_ready=1 → output order ch0 b0..b2 then ch2 b0..b2; out_sop on beats 1 and 4, out_eop on beats 3 and 6; pkt_count=2.
- All 4 channels continuously valid with 1-beat packets → grant sequence 0,1,2,3,0; one output beat every 2 cycles.
- fifo_level=8000 with ch1 requesting → no grant and in_ready=0; level drops to 7999 → grant ch1 next cycle. Level jumps to 8191 mid-packet → packet completes.
- out_ready toggles 1,0,1 during a 4-beat ch3 packet → out_valid asserts only in cycles following out_ready=1; data matches input order; no beat is lost or duplicated.
- Ch1 offers a 2-beat packet with sop=0 → proto_err pulses once, both beats consumed with no out_valid, drop_count=1. A sop mid-packet on ch0 → that beat is output with eop=1 and error=1.
- reset_n asserted mid-packet on ch2 → all outputs return to 0 asynchronously; after release, the first grant goes to ch0.

Source files
------------

// File: rtl/sonic_vc_tx_arbiter.sv
// Packet-atomic round-robin merge of per-VC Avalon-ST TX sources into the TX FIFO.
// Headless packets are discarded; forwarded/dropped packets are counted for CSRs.
module sonic_vc_tx_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 2,
  parameter int LEVEL_W = 14,
  parameter int HI_WM   = 8000
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*DATA_W-1:0]    in_data,
  input  logic [NUM_CH*EMPTY_W-1:0]   in_empty,
  input  logic [NUM_CH-1:0]           in_error,
  input  logic [NUM_CH-1:0]           in_sop,
  input  logic [NUM_CH-1:0]           in_eop,
  output logic [NUM_CH-1:0]           in_ready,
  input  logic [NUM_CH-1:0]           chan_enable,
  input  logic [LEVEL_W-1:0]          fifo_level,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [EMPTY_W-1:0]          out_empty,
  output logic                        out_error,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [2:0]                  grant_ch,
  output logic                        busy,
  output logic                        proto_err,
  output logic [31:0]                 pkt_count,
  output logic [15:0]                 drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP
  } state_t;

  state_t state;
  logic [2:0] last;
  logic first;

  logic [NUM_CH-1:0] cand;
  logic found;
  logic [2:0] pick;
  logic pick_sop;

  logic g_valid;
  logic [DATA_W-1:0] g_data;
  logic [EMPTY_W-1:0] g_empty;
  logic g_error;
  logic g_sop;
  logic g_eop;
  logic take;
  logic accept;
  logic below_wm;

  assign cand = in_valid & chan_enable;
  assign below_wm = fifo_level < LEVEL_W'(HI_WM);
  assign busy = (state != IDLE);

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    pick = last;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && cand[j]
            && j == (int'(last) + k) % NUM_CH) begin
          found = 1'b1;
          pick = 3'(j);
        end
      end
    end
  end

  always_comb begin
    pick_sop = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick == 3'(i)) pick_sop = in_sop[i];
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data = '0;
    g_empty = '0;
    g_error = 1'b0;
    g_sop = 1'b0;
    g_eop = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch == 3'(i)) begin
        g_valid = in_valid[i];
        g_data = in_data[i*DATA_W +: DATA_W];
        g_empty = in_empty[i*EMPTY_W +: EMPTY_W];
        g_error = in_error[i];
        g_sop = in_sop[i];
        g_eop = in_eop[i];
      end
    end
  end

  // Forwarding follows the sink; dropping never waits on it.
  assign take = (state == DROP)
              | ((state == XFER) & out_ready);
  assign accept = g_valid & take;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_ch == 3'(i)) in_ready[i] = take;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last <= 3'(NUM_CH - 1);
      first <= 1'b0;
      grant_ch <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_empty <= '0;
      out_error <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      proto_err <= 1'b0;
      pkt_count <= '0;
      drop_count <= '0;
    end else begin
      out_valid <= 1'b0;
      proto_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && below_wm) begin
            grant_ch <= pick;
            last <= pick;
            first <= 1'b1;
            if (pick_sop) begin
              state <= XFER;
            end else begin
              state <= DROP;
              proto_err <= 1'b1;
            end
          end
        end
        XFER: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_data <= g_data;
            out_empty <= g_empty;
            out_sop <= g_sop;
            first <= 1'b0;
            // A fresh sop cuts the current packet short.
            if (g_sop && !first) begin
              out_eop <= 1'b1;
              out_error <= 1'b1;
              proto_err <= 1'b1;
              pkt_count <= pkt_count + 32'd1;
              state <= IDLE;
            end else begin
              out_eop <= g_eop;
              out_error <= g_error;
              if (g_eop) begin
                pkt_count <= pkt_count + 32'd1;
                state <= IDLE;
              end
            end
          end
        end
        DROP: begin
          if (accept && g_eop) begin
            if (drop_count != 16'hFFFF)
              drop_count <= drop_count + 16'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
